// File: rtl/div_clk_monitor_if.sv
// Status bundle between the divided-clock monitor and its status/debug consumer.
interface div_clk_monitor_if #(
   parameter int unsigned LEN_W = 4,
   parameter int unsigned CNT_W = 16
);
   logic             div_clk;
   logic             err_clr;
   logic             rise_pulse;
   logic             fall_pulse;
   logic             locked;
   logic             err;
   logic [LEN_W-1:0] half_len;
   logic [CNT_W-1:0] edge_cnt;

   modport master (
      output div_clk, err_clr,
      input  rise_pulse, fall_pulse, locked, err, half_len, edge_cnt
   );

   modport slave (
      input  div_clk, err_clr,
      output rise_pulse, fall_pulse, locked, err, half_len, edge_cnt
   );
endinterface

// File: rtl/div_clk_monitor.sv
// Measures div_clk half-periods on clk, tracks lock and flags sticky errors.
// Optional macro DIVMON_TOL_EN: accept half-periods within +/-1 cycle of HALF.
module div_clk_monitor #(
   parameter int unsigned HALF     = 2,
   parameter int unsigned LOCK_CNT = 4,
   parameter int unsigned TO_MAX   = 8,
   parameter int unsigned LEN_W    = 4,
   parameter int unsigned CNT_W    = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   div_clk_monitor_if.slave  mon
);

   localparam int unsigned GC_W = $clog2(LOCK_CNT + 1);
   localparam logic [LEN_W-1:0] RUN_MAX = '1;

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_ACQ    = 2'd1;
   localparam logic [1:0] ST_LOCKED = 2'd2;

   logic [1:0]       r_state;
   logic [1:0]       w_state_nxt;
   logic             r_s_q;
   logic [LEN_W-1:0] r_run;
   logic [GC_W-1:0]  r_good_cnt;
   logic [GC_W-1:0]  w_good_nxt;
   logic             r_rise;
   logic             r_fall;
   logic             r_locked;
   logic             r_err;
   logic [LEN_W-1:0] r_half_len;
   logic [CNT_W-1:0] r_edge_cnt;

   logic w_edge;
   logic w_good;
   logic w_timeout;
   logic w_err_set;

   assign w_edge    = (mon.div_clk != r_s_q);
   assign w_timeout = !w_edge && (r_run == LEN_W'(TO_MAX - 1));

`ifdef DIVMON_TOL_EN
   assign w_good = (r_run >= LEN_W'(HALF - 1)) && (r_run <= LEN_W'(HALF + 1));
`else
   assign w_good = (r_run == LEN_W'(HALF));
`endif

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= ST_IDLE;
         r_good_cnt <= '0;
      end else begin
         r_state    <= w_state_nxt;
         r_good_cnt <= w_good_nxt;
      end
   end

   // Lock FSM: next state, good-run count and error request
   always_comb begin
      w_state_nxt = r_state;
      w_good_nxt  = r_good_cnt;
      w_err_set   = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_edge) begin
               w_state_nxt = ST_ACQ;
               w_good_nxt  = '0;
            end
         end
         ST_ACQ: begin
            if (w_timeout) begin
               w_state_nxt = ST_IDLE;
            end else if (w_edge) begin
               if (w_good) begin
                  w_good_nxt = r_good_cnt + GC_W'(1);
                  if (r_good_cnt == GC_W'(LOCK_CNT - 1)) w_state_nxt = ST_LOCKED;
               end else begin
                  w_good_nxt = '0;
               end
            end
         end
         ST_LOCKED: begin
            if (w_timeout) begin
               w_err_set   = 1'b1;
               w_state_nxt = ST_IDLE;
            end else if (w_edge && !w_good) begin
               w_err_set   = 1'b1;
               w_state_nxt = ST_ACQ;
               w_good_nxt  = '0;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
            w_good_nxt  = '0;
         end
      endcase
   end

   // Sampling, run-length measurement and registered outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_s_q      <= 1'b0;
         r_run      <= '0;
         r_rise     <= 1'b0;
         r_fall     <= 1'b0;
         r_locked   <= 1'b0;
         r_err      <= 1'b0;
         r_half_len <= '0;
         r_edge_cnt <= '0;
      end else begin
         r_s_q    <= mon.div_clk;
         r_rise   <= w_edge && mon.div_clk;
         r_fall   <= w_edge && !mon.div_clk;
         r_locked <= (w_state_nxt == ST_LOCKED);
         if (w_edge) begin
            r_run      <= LEN_W'(1);
            r_edge_cnt <= r_edge_cnt + CNT_W'(1);
            if (r_state != ST_IDLE) r_half_len <= r_run;
         end else if (r_run != RUN_MAX) begin
            r_run <= r_run + LEN_W'(1);
         end
         // A new error outranks a simultaneous clear
         if (w_err_set)        r_err <= 1'b1;
         else if (mon.err_clr) r_err <= 1'b0;
      end
   end

   assign mon.rise_pulse = r_rise;
   assign mon.fall_pulse = r_fall;
   assign mon.locked     = r_locked;
   assign mon.err        = r_err;
   assign mon.half_len   = r_half_len;
   assign mon.edge_cnt   = r_edge_cnt;

endmodule

// File: tb/tb_div_clk_monitor.sv
// Directed bench for div_clk_monitor: lock, bad halves, timeout, err_clr, wrap, tolerance.
module tb_div_clk_monitor;

   logic clk;
   logic rst_n;
   int   checks;
   int   errors;

   div_clk_monitor_if #(.LEN_W(4), .CNT_W(16)) bus ();
   div_clk_monitor_if #(.LEN_W(4), .CNT_W(4))  bus4 ();

   div_clk_monitor #(.HALF(2), .LOCK_CNT(4), .TO_MAX(8), .LEN_W(4), .CNT_W(16)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .mon   (bus)
   );

   div_clk_monitor #(.HALF(2), .LOCK_CNT(4), .TO_MAX(8), .LEN_W(4), .CNT_W(4)) dut4 (
      .clk   (clk),
      .rst_n (rst_n),
      .mon   (bus4)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   // One sample: drive at negedge, observe 1ns after the following posedge
   task automatic tick(input logic v, input logic clr);
      @(negedge clk);
      bus.div_clk  = v;
      bus.err_clr  = clr;
      bus4.div_clk = v;
      bus4.err_clr = clr;
      @(posedge clk);
      #1;
   endtask

   // Starting just after a falling edge (run=1): four good halves of 2
   task automatic relock();
      tick(0, 0);
      tick(1, 0); tick(1, 0);
      tick(0, 0); tick(0, 0);
      tick(1, 0); tick(1, 0);
      tick(0, 0);
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      bus.div_clk = 1'b0; bus.err_clr = 1'b0;
      bus4.div_clk = 1'b0; bus4.err_clr = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      if ({bus.rise_pulse, bus.fall_pulse, bus.locked, bus.err} !== 4'b0000) begin
         $display("FAIL reset_flags: got %b exp 0000", {bus.rise_pulse, bus.fall_pulse, bus.locked, bus.err});
         errors++;
      end
      checks++;
      if (bus.half_len !== 4'd0 || bus.edge_cnt !== 16'd0) begin
         $display("FAIL reset_counts: half_len %0d edge_cnt %0d exp 0 0", bus.half_len, bus.edge_cnt);
         errors++;
      end
      checks++;
      @(negedge clk);
      rst_n = 1'b1;
      tick(0, 0);
      if (bus.edge_cnt !== 16'd0 || bus.rise_pulse !== 1'b0) begin
         $display("FAIL reset_noedge: edge_cnt %0d rise %0b exp 0 0", bus.edge_cnt, bus.rise_pulse);
         errors++;
      end
      checks++;
   endtask

   task automatic test_lock();
      tick(1, 0);
      if (bus.rise_pulse !== 1'b1 || bus.fall_pulse !== 1'b0) begin
         $display("FAIL lock_first_rise: rise %0b fall %0b exp 1 0", bus.rise_pulse, bus.fall_pulse);
         errors++;
      end
      checks++;
      if (bus.half_len !== 4'd0) begin
         $display("FAIL lock_first_unmeasured: half_len %0d exp 0", bus.half_len);
         errors++;
      end
      checks++;
      tick(1, 0);
      if (bus.rise_pulse !== 1'b0 || bus.fall_pulse !== 1'b0) begin
         $display("FAIL lock_no_strobe: rise %0b fall %0b exp 0 0", bus.rise_pulse, bus.fall_pulse);
         errors++;
      end
      checks++;
      tick(0, 0);
      if (bus.fall_pulse !== 1'b1 || bus.rise_pulse !== 1'b0 || bus.half_len !== 4'd2) begin
         $display("FAIL lock_fall: fall %0b rise %0b half_len %0d exp 1 0 2", bus.fall_pulse, bus.rise_pulse, bus.half_len);
         errors++;
      end
      checks++;
      tick(0, 0);
      tick(1, 0); tick(1, 0);
      tick(0, 0); tick(0, 0);
      if (bus.locked !== 1'b0) begin
         $display("FAIL lock_early: locked %0b exp 0", bus.locked);
         errors++;
      end
      checks++;
      tick(1, 0);
      if (bus.locked !== 1'b1 || bus.err !== 1'b0 || bus.half_len !== 4'd2 || bus.edge_cnt !== 16'd5) begin
         $display("FAIL lock_locked: locked %0b err %0b half_len %0d edge_cnt %0d exp 1 0 2 5",
                  bus.locked, bus.err, bus.half_len, bus.edge_cnt);
         errors++;
      end
      checks++;
   endtask

   task automatic test_stretch();
      tick(1, 0); tick(1, 0);
      if (bus.locked !== 1'b1 || bus.err !== 1'b0) begin
         $display("FAIL stretch_before: locked %0b err %0b exp 1 0", bus.locked, bus.err);
         errors++;
      end
      checks++;
      tick(0, 0);
      if (bus.err !== 1'b1 || bus.locked !== 1'b0 || bus.half_len !== 4'd3) begin
         $display("FAIL stretch_err: err %0b locked %0b half_len %0d exp 1 0 3", bus.err, bus.locked, bus.half_len);
         errors++;
      end
      checks++;
      relock();
      if (bus.locked !== 1'b1 || bus.err !== 1'b1 || bus.half_len !== 4'd2 || bus.edge_cnt !== 16'd10) begin
         $display("FAIL stretch_relock: locked %0b err %0b half_len %0d edge_cnt %0d exp 1 1 2 10",
                  bus.locked, bus.err, bus.half_len, bus.edge_cnt);
         errors++;
      end
      checks++;
   endtask

   task automatic test_err_clr();
      tick(0, 1);
      if (bus.err !== 1'b0 || bus.locked !== 1'b1) begin
         $display("FAIL clr_plain: err %0b locked %0b exp 0 1", bus.err, bus.locked);
         errors++;
      end
      checks++;
      tick(1, 0); tick(1, 0); tick(1, 0);
      tick(0, 1);
      if (bus.err !== 1'b1 || bus.locked !== 1'b0 || bus.half_len !== 4'd3) begin
         $display("FAIL clr_vs_error: err %0b locked %0b half_len %0d exp 1 0 3", bus.err, bus.locked, bus.half_len);
         errors++;
      end
      checks++;
      relock();
      if (bus.locked !== 1'b1 || bus.edge_cnt !== 16'd16) begin
         $display("FAIL clr_relock: locked %0b edge_cnt %0d exp 1 16", bus.locked, bus.edge_cnt);
         errors++;
      end
      checks++;
   endtask

   task automatic test_timeout();
      tick(0, 1);
      repeat (5) tick(0, 0);
      if (bus.locked !== 1'b1 || bus.err !== 1'b0) begin
         $display("FAIL timeout_early: locked %0b err %0b exp 1 0", bus.locked, bus.err);
         errors++;
      end
      checks++;
      tick(0, 0);
      if (bus.locked !== 1'b0 || bus.err !== 1'b1) begin
         $display("FAIL timeout_err: locked %0b err %0b exp 0 1", bus.locked, bus.err);
         errors++;
      end
      checks++;
      tick(0, 0);
      tick(1, 0);
      if (bus.rise_pulse !== 1'b1 || bus.half_len !== 4'd2 || bus.edge_cnt !== 16'd17 || bus.locked !== 1'b0) begin
         $display("FAIL timeout_unmeasured: rise %0b half_len %0d edge_cnt %0d locked %0b exp 1 2 17 0",
                  bus.rise_pulse, bus.half_len, bus.edge_cnt, bus.locked);
         errors++;
      end
      checks++;
   endtask

   task automatic test_tolerance();
      tick(1, 0);
      tick(0, 0); tick(0, 0);
      tick(1, 0); tick(1, 0);
      tick(0, 0); tick(0, 0);
      tick(1, 0);
      if (bus.locked !== 1'b1) begin
         $display("FAIL tol_lock: locked %0b exp 1", bus.locked);
         errors++;
      end
      checks++;
      tick(1, 1);
      tick(1, 0);
      tick(0, 0);
`ifdef DIVMON_TOL_EN
      if (bus.locked !== 1'b1 || bus.err !== 1'b0 || bus.half_len !== 4'd3) begin
         $display("FAIL tol_half3: locked %0b err %0b half_len %0d exp 1 0 3", bus.locked, bus.err, bus.half_len);
         errors++;
      end
`else
      if (bus.locked !== 1'b0 || bus.err !== 1'b1 || bus.half_len !== 4'd3) begin
         $display("FAIL tol_half3: locked %0b err %0b half_len %0d exp 0 1 3", bus.locked, bus.err, bus.half_len);
         errors++;
      end
`endif
      checks++;
      if (bus.edge_cnt !== 16'd22) begin
         $display("FAIL tol_edges: edge_cnt %0d exp 22", bus.edge_cnt);
         errors++;
      end
      checks++;
   endtask

   task automatic test_wrap();
      logic       v;
      logic [3:0] exp_cnt;
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      bus.div_clk = 1'b0; bus4.div_clk = 1'b0;
      #1;
      if (bus.edge_cnt !== 16'd0 || bus.half_len !== 4'd0 || bus.err !== 1'b0 || bus.locked !== 1'b0) begin
         $display("FAIL midreset: edge_cnt %0d half_len %0d err %0b locked %0b exp 0 0 0 0",
                  bus.edge_cnt, bus.half_len, bus.err, bus.locked);
         errors++;
      end
      checks++;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      for (int e = 1; e <= 16; e++) begin
         v = (e % 2 == 1);
         exp_cnt = 4'(e % 16);
         tick(v, 0);
         if (bus4.edge_cnt !== exp_cnt || bus4.locked !== (e >= 5)) begin
            $display("FAIL wrap_edge%0d: edge_cnt %0d locked %0b exp %0d %0b",
                     e, bus4.edge_cnt, bus4.locked, exp_cnt, (e >= 5));
            errors++;
         end
         checks++;
         if (e == 1 && bus.half_len !== 4'd0) begin
            $display("FAIL wrap_first_unmeasured: half_len %0d exp 0", bus.half_len);
            errors++;
         end
         if (e == 1) checks++;
         tick(v, 0);
      end
      if (bus4.edge_cnt !== 4'd0 || bus4.locked !== 1'b1 || bus4.err !== 1'b0 || bus.edge_cnt !== 16'd16) begin
         $display("FAIL wrap_end: edge_cnt4 %0d locked %0b err %0b edge_cnt16 %0d exp 0 1 0 16",
                  bus4.edge_cnt, bus4.locked, bus4.err, bus.edge_cnt);
         errors++;
      end
      checks++;
   endtask

   initial begin
      checks = 0;
      errors = 0;
      test_reset();
      test_lock();
      test_stretch();
      test_err_clr();
      test_timeout();
      test_tolerance();
      test_wrap();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
